// File: rtl/map_table_ckpt.sv
// Register alias table: WAYS-wide rename with intra-group forwarding, CDB ready snooping,
// retire clearing and NUM_CKPT branch checkpoints with single-cycle restore.
module map_table_ckpt #(
    parameter int unsigned NUM_AREGS = 32,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned WAYS      = 2,
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned NUM_CKPT  = 4,
    localparam int unsigned AREG_W   = 5,
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned CK_W     = $clog2(NUM_CKPT)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WAYS-1:0]            ren_valid,
    input  logic [WAYS*AREG_W-1:0]     ren_dest,
    input  logic [WAYS*TAG_W-1:0]      ren_tag,
    input  logic [WAYS*AREG_W-1:0]     ren_srca,
    input  logic [WAYS*AREG_W-1:0]     ren_srcb,
    output logic [WAYS*TAG_W-1:0]      srca_tag,
    output logic [WAYS-1:0]            srca_ready,
    output logic [WAYS*TAG_W-1:0]      srcb_tag,
    output logic [WAYS-1:0]            srcb_ready,
    output logic [WAYS*TAG_W-1:0]      old_tag,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [WAYS-1:0]            ret_valid,
    input  logic [WAYS*TAG_W-1:0]      ret_tag,
    input  logic                       ckpt_take,
    input  logic [WAY_W-1:0]           ckpt_way,
    output logic [CK_W-1:0]            ckpt_id,
    output logic                       ckpt_full,
    input  logic                       ckpt_free,
    input  logic [CK_W-1:0]            ckpt_free_id,
    input  logic                       ckpt_restore,
    input  logic [CK_W-1:0]            ckpt_rest_id
);

    localparam logic [TAG_W-1:0]  NULL_TAG = '1;
    localparam logic [AREG_W-1:0] ZERO_REG = AREG_W'(NUM_AREGS - 1);

    logic             tbl_valid_q [NUM_AREGS];
    logic             tbl_valid_d [NUM_AREGS];
    logic             tbl_ready_q [NUM_AREGS];
    logic             tbl_ready_d [NUM_AREGS];
    logic [TAG_W-1:0] tbl_tag_q   [NUM_AREGS];
    logic [TAG_W-1:0] tbl_tag_d   [NUM_AREGS];

    logic             snap_valid_q [NUM_CKPT][NUM_AREGS];
    logic             snap_valid_d [NUM_CKPT][NUM_AREGS];
    logic             snap_ready_q [NUM_CKPT][NUM_AREGS];
    logic             snap_ready_d [NUM_CKPT][NUM_AREGS];
    logic [TAG_W-1:0] snap_tag_q   [NUM_CKPT][NUM_AREGS];
    logic [TAG_W-1:0] snap_tag_d   [NUM_CKPT][NUM_AREGS];

    logic [NUM_CKPT-1:0] live_q, live_d;
    logic [NUM_CKPT-1:0] older_q [NUM_CKPT];
    logic [NUM_CKPT-1:0] older_d [NUM_CKPT];

    logic             base_valid [NUM_AREGS];
    logic             base_ready [NUM_AREGS];
    logic             new_valid  [NUM_AREGS];
    logic             new_ready  [NUM_AREGS];
    logic [TAG_W-1:0] new_tag    [NUM_AREGS];

    logic [AREG_W-1:0] dest_a [WAYS];
    logic [AREG_W-1:0] srca_a [WAYS];
    logic [AREG_W-1:0] srcb_a [WAYS];
    logic [TAG_W-1:0]  tag_a  [WAYS];
    logic [WAYS-1:0]   ren_en;

    logic [CK_W-1:0]     alloc_id;
    logic                full_c;
    logic                restore_en;
    logic                take_en;
    logic [NUM_CKPT-1:0] freed;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] t,
                                     input logic [CDB_PORTS-1:0] v,
                                     input logic [CDB_PORTS*TAG_W-1:0] tags);
        cdb_hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++)
            if (v[p] && tags[p*TAG_W +: TAG_W] == t) cdb_hit = 1'b1;
    endfunction

    function automatic logic ret_hit(input logic [TAG_W-1:0] t,
                                     input logic [WAYS-1:0] v,
                                     input logic [WAYS*TAG_W-1:0] tags);
        ret_hit = 1'b0;
        for (int p = 0; p < WAYS; p++)
            if (v[p] && tags[p*TAG_W +: TAG_W] == t) ret_hit = 1'b1;
    endfunction

    // Unpack per-way fields; renames to the zero register or with a NULL tag are ignored
    always_comb begin : unpack
        for (int w = 0; w < WAYS; w++) begin
            dest_a[w] = ren_dest[w*AREG_W +: AREG_W];
            srca_a[w] = ren_srca[w*AREG_W +: AREG_W];
            srcb_a[w] = ren_srcb[w*AREG_W +: AREG_W];
            tag_a[w]  = ren_tag[w*TAG_W +: TAG_W];
            ren_en[w] = ren_valid[w] && (dest_a[w] != ZERO_REG) && (tag_a[w] != NULL_TAG);
        end
    end

    // Combinational lookup: table (with CDB bypass) overridden by older ways in this group
    always_comb begin : lookup
        logic [AREG_W-1:0] src;
        logic [TAG_W-1:0]  hit_tag;
        logic              hit_rdy;
        srca_tag   = '0;
        srca_ready = '0;
        srcb_tag   = '0;
        srcb_ready = '0;
        old_tag    = '0;
        src        = '0;
        hit_tag    = NULL_TAG;
        hit_rdy    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < 3; s++) begin
                src     = (s == 0) ? srca_a[w] : ((s == 1) ? srcb_a[w] : dest_a[w]);
                hit_tag = NULL_TAG;
                hit_rdy = 1'b0;
                if (src != ZERO_REG && tbl_valid_q[src]) begin
                    hit_tag = tbl_tag_q[src];
                    hit_rdy = tbl_ready_q[src] || cdb_hit(tbl_tag_q[src], cdb_valid, cdb_tag);
                end
                for (int v = 0; v < w; v++) begin
                    if (ren_en[v] && dest_a[v] == src) begin
                        hit_tag = tag_a[v];
                        hit_rdy = 1'b0;
                    end
                end
                if (reset) begin
                    hit_tag = NULL_TAG;
                    hit_rdy = 1'b0;
                end
                if (s == 0) begin
                    srca_tag[w*TAG_W +: TAG_W] = hit_tag;
                    srca_ready[w]              = hit_rdy;
                end else if (s == 1) begin
                    srcb_tag[w*TAG_W +: TAG_W] = hit_tag;
                    srcb_ready[w]              = hit_rdy;
                end else begin
                    old_tag[w*TAG_W +: TAG_W]  = hit_tag;
                end
            end
        end
    end

    // Lowest free slot from the pre-cycle free map
    always_comb begin : alloc
        logic found;
        alloc_id = '0;
        found    = 1'b0;
        for (int j = 0; j < NUM_CKPT; j++) begin
            if (!live_q[j] && !found) begin
                alloc_id = CK_W'(j);
                found    = 1'b1;
            end
        end
        full_c    = &live_q;
        ckpt_id   = reset ? '0 : alloc_id;
        ckpt_full = !reset && full_c;
    end

    always_comb begin : next_state
        restore_en = ckpt_restore && live_q[ckpt_rest_id];
        take_en    = ckpt_take && !full_c && !restore_en;

        for (int a = 0; a < NUM_AREGS; a++) begin
            base_valid[a] = tbl_valid_q[a] && !ret_hit(tbl_tag_q[a], ret_valid, ret_tag);
            base_ready[a] = base_valid[a] &&
                            (tbl_ready_q[a] || cdb_hit(tbl_tag_q[a], cdb_valid, cdb_tag));
            new_valid[a]  = base_valid[a];
            new_ready[a]  = base_ready[a];
            new_tag[a]    = tbl_tag_q[a];
        end
        // Snapshot image only sees renames up to and including the branch way
        for (int w = 0; w < WAYS; w++) begin
            if (ren_en[w] && WAY_W'(w) <= ckpt_way) begin
                new_valid[dest_a[w]] = 1'b1;
                new_ready[dest_a[w]] = 1'b0;
                new_tag[dest_a[w]]   = tag_a[w];
            end
        end

        for (int j = 0; j < NUM_CKPT; j++) begin
            for (int a = 0; a < NUM_AREGS; a++) begin
                snap_valid_d[j][a] = snap_valid_q[j][a] &&
                                     !ret_hit(snap_tag_q[j][a], ret_valid, ret_tag);
                snap_ready_d[j][a] = snap_valid_d[j][a] && (snap_ready_q[j][a] ||
                                     cdb_hit(snap_tag_q[j][a], cdb_valid, cdb_tag));
                snap_tag_d[j][a]   = snap_tag_q[j][a];
                if (take_en && CK_W'(j) == alloc_id) begin
                    snap_valid_d[j][a] = new_valid[a];
                    snap_ready_d[j][a] = new_ready[a];
                    snap_tag_d[j][a]   = new_tag[a];
                end
            end
        end

        for (int a = 0; a < NUM_AREGS; a++) begin
            if (restore_en) begin
                tbl_valid_d[a] = snap_valid_d[ckpt_rest_id][a];
                tbl_ready_d[a] = snap_ready_d[ckpt_rest_id][a];
                tbl_tag_d[a]   = snap_tag_d[ckpt_rest_id][a];
            end else begin
                tbl_valid_d[a] = base_valid[a];
                tbl_ready_d[a] = base_ready[a];
                tbl_tag_d[a]   = tbl_tag_q[a];
            end
        end
        if (!restore_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (ren_en[w]) begin
                    tbl_valid_d[dest_a[w]] = 1'b1;
                    tbl_ready_d[dest_a[w]] = 1'b0;
                    tbl_tag_d[dest_a[w]]   = tag_a[w];
                end
            end
        end

        // Freed slots also drop out of every older mask so a reallocated id starts clean
        freed = '0;
        if (ckpt_free) freed[ckpt_free_id] = live_q[ckpt_free_id];
        if (restore_en) begin
            for (int j = 0; j < NUM_CKPT; j++)
                if (CK_W'(j) == ckpt_rest_id || older_q[j][ckpt_rest_id]) freed[j] = live_q[j];
        end
        live_d = live_q & ~freed;
        for (int j = 0; j < NUM_CKPT; j++) older_d[j] = older_q[j] & ~freed;
        if (take_en) begin
            live_d[alloc_id]  = 1'b1;
            older_d[alloc_id] = live_q & ~freed;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            live_q <= '0;
            for (int a = 0; a < NUM_AREGS; a++) begin
                tbl_valid_q[a] <= 1'b0;
                tbl_ready_q[a] <= 1'b0;
                tbl_tag_q[a]   <= NULL_TAG;
            end
            for (int j = 0; j < NUM_CKPT; j++) begin
                older_q[j] <= '0;
                for (int a = 0; a < NUM_AREGS; a++) begin
                    snap_valid_q[j][a] <= 1'b0;
                    snap_ready_q[j][a] <= 1'b0;
                    snap_tag_q[j][a]   <= NULL_TAG;
                end
            end
        end else begin
            live_q <= live_d;
            for (int a = 0; a < NUM_AREGS; a++) begin
                tbl_valid_q[a] <= tbl_valid_d[a];
                tbl_ready_q[a] <= tbl_ready_d[a];
                tbl_tag_q[a]   <= tbl_tag_d[a];
            end
            for (int j = 0; j < NUM_CKPT; j++) begin
                older_q[j] <= older_d[j];
                for (int a = 0; a < NUM_AREGS; a++) begin
                    snap_valid_q[j][a] <= snap_valid_d[j][a];
                    snap_ready_q[j][a] <= snap_ready_d[j][a];
                    snap_tag_q[j][a]   <= snap_tag_d[j][a];
                end
            end
        end
    end

endmodule
